key_space_scheduler: RTL and testbench
======================================

# key_space_scheduler

Work dispatcher for the RC4 brute-force search. It shares the 2^KEY_WIDTH secret-key space between NUM_CORES parallel decryption cores by handing out fixed-size key chunks, one chunk per grant, in round-robin order. It collects per-core hit reports, latches the first winning key and stops every core. It sits between the top-level control (start, ROM-loaded status, result display) and the array of decryption cores.

## Interface
- NUM_CORES, 4: number of requesting cores, 2..8.
- KEY_WIDTH, 22: width of the searchable key field; the upper 2 bits of the 24-bit key are always 0.
- CHUNK_SIZE, 4096: keys per grant; a power of two and ≤ 2^KEY_WIDTH.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new search.
- rom_ready  in  1  level; encrypted message loaded, so grants are allowed.
- req  in  NUM_CORES  level per core; the core is idle and wants a chunk.
- hit  in  NUM_CORES  one-cycle pulse per core; the core found a valid message.
- hit_key  in  NUM_CORES*24  flattened; core i's key is in bits [24i+23:24i], valid with hit[i].
- ack  out  NUM_CORES  one-hot, one-cycle grant pulse.
- chunk_base  out  KEY_WIDTH  first key of the granted chunk; valid while ack is nonzero.
- chunk_last  out  KEY_WIDTH  chunk_base + CHUNK_SIZE − 1; valid while ack is nonzero.
- stop_all  out  1  level; all cores must halt.
- busy  out  1  high in every state except IDLE and FINISH.
- done  out  1  search finished (key found or space exhausted).
- found  out  1  a valid key was latched.
- found_key  out  24  the winning key.
- found_core  out  $clog2(NUM_CORES)  index of the winning core.

## Operation
- States: IDLE, WAIT_ROM, DISPATCH, DRAIN, FINISH.
- IDLE → WAIT_ROM on start.
  - Entering WAIT_ROM clears next_base, outstanding, exhausted, rr_ptr, found, found_key, found_core, done and stop_all.
- WAIT_ROM → DISPATCH when rom_ready = 1.
- DISPATCH arbitration:
  - Eligible set = req & ~ack_prev, where ack_prev is the registered ack of the previous cycle. This masks a core for one cycle after its grant.
  - The winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_CORES.
  - At most one grant per cycle.
  - On a grant:
    - ack[w] = 1, chunk_base = next_base, chunk_last = next_base + CHUNK_SIZE − 1.
    - next_base += CHUNK_SIZE, computed in KEY_WIDTH+1 bits.
    - outstanding[w] = 1, rr_ptr = w + 1 (wraps).
  - When the add carries out of KEY_WIDTH, exhausted = 1 and the next state is DRAIN. The last chunk is still granted.
- outstanding[i] clears in any cycle where req[i] = 1 and ack_prev[i] = 0. A re-request means the previous chunk is finished.
- DRAIN: no grants. → FINISH when outstanding = 0, with found = 0 and done = 1.
- Hit handling, DISPATCH or DRAIN:
  - Any hit bit set → FINISH.
  - The lowest set index wins. found_key and found_core latch from that core; found = 1, stop_all = 1, done = 1.
  - A hit takes priority over a grant in the same cycle: ack stays 0 and next_base does not advance.
- Hits in IDLE, WAIT_ROM or FINISH are ignored.
- FINISH: all result outputs hold. start → WAIT_ROM, which clears the results as above. Other inputs are ignored.
- start is ignored outside IDLE and FINISH.

## Timing
- Every output is a register, reset to 0. reset_n low forces IDLE immediately, from any state and mid-grant.
- Grant latency: req sampled high at edge k gives ack visible after edge k. This means one cycle from the DISPATCH cycle in which req is seen.
- Maximum grant rate is one per cycle. A single requesting core is granted at most every 2 cycles because of the ack_prev mask.
- Cores must drop req in the cycle after ack, and must ignore chunk_base/chunk_last outside ack.
- Hit latency: hit at edge k → found, stop_all and done all high after edge k, simultaneously.
- stop_all stays high until the next start or reset.
- Number of chunks = 2^KEY_WIDTH / CHUNK_SIZE. The last chunk_last equals 2^KEY_WIDTH − 1.

## Test plan
- Full sweep, no hit (KEY_WIDTH = 6, CHUNK_SIZE = 16, NUM_CORES = 2, req held high):
  - Grants core0 base 0, core1 base 16, core0 base 32, core1 base 48. chunk_last values are 15, 31, 47, 63.
  - Then DRAIN. When both cores re-request, done = 1, found = 0, stop_all = 0.
- Hit mid-search:
  - hit[1] = 1 with hit_key[1] = 24'h00002A → next cycle found = 1, found_key = 24'h00002A, found_core = 1, stop_all = done = 1.
  - No further ack.
- Simultaneous hits: hit = 4'b1010 (NUM_CORES = 4) → found_core = 1 and the core-1 key is latched.
- Hit and grant collide: req[0] and hit[2] in the same cycle → ack = 0, next_base unchanged, found_core = 2.
- ROM gating and fairness:
  - With rom_ready = 0, no ack for 20 cycles. When it rises, all 4 cores request.
  - Acks go 0, 1, 2, 3 on consecutive cycles, with bases 0, CHUNK_SIZE, 2·CHUNK_SIZE, 3·CHUNK_SIZE.
- Async reset and restart:
  - reset_n low during DISPATCH → all outputs 0 immediately.
  - start after FINISH → results cleared, and the new search starts at base 0.

Source files
------------

// File: rtl/key_space_scheduler.sv
// Key-space dispatcher for the RC4 brute-force array: hands out fixed-size key
// chunks round-robin to idle cores, latches the first reported hit and halts all cores.
module key_space_scheduler #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned KEY_WIDTH  = 22,
  parameter int unsigned CHUNK_SIZE = 4096
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           rom_ready,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES-1:0]           hit,
  input  logic [NUM_CORES*24-1:0]        hit_key,
  output logic [NUM_CORES-1:0]           ack,
  output logic [KEY_WIDTH-1:0]           chunk_base,
  output logic [KEY_WIDTH-1:0]           chunk_last,
  output logic                           stop_all,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [23:0]                    found_key,
  output logic [$clog2(NUM_CORES)-1:0]   found_core
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);
  localparam int unsigned SUM_W = KEY_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROM,
    S_DISPATCH,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] next_base_q, next_base_d;
  logic [NUM_CORES-1:0] outstanding_q, outstanding_d;
  logic                 exhausted_q, exhausted_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0] ack_d;
  logic [KEY_WIDTH-1:0] chunk_base_d, chunk_last_d;
  logic                 stop_all_d, busy_d, done_d, found_d;
  logic [23:0]          found_key_d;
  logic [IDX_W-1:0]     found_core_d;

  logic [NUM_CORES-1:0] eligible;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       cand;
  logic [IDX_W-1:0]     hit_idx;
  logic [23:0]          hit_key_sel;
  logic [SUM_W-1:0]     next_sum;

  // A core is masked for the cycle right after its own grant (ack is ack_prev here).
  assign eligible = req & ~ack;
  assign next_sum = {1'b0, next_base_q} + SUM_W'(CHUNK_SIZE);

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CORES)) begin
        cand = cand - (IDX_W+1)'(NUM_CORES);
      end
      if (!grant_valid && eligible[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Lowest-index hit wins; scan downward so the lowest set bit is written last.
  always_comb begin
    hit_idx     = '0;
    hit_key_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx     = IDX_W'(i);
        hit_key_sel = hit_key[i*24 +: 24];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    next_base_d   = next_base_q;
    outstanding_d = outstanding_q & ~eligible;
    exhausted_d   = exhausted_q;
    rr_ptr_d      = rr_ptr_q;
    ack_d         = '0;
    chunk_base_d  = chunk_base;
    chunk_last_d  = chunk_last;
    stop_all_d    = stop_all;
    done_d        = done;
    found_d       = found;
    found_key_d   = found_key;
    found_core_d  = found_core;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d = S_WAIT_ROM;
        end
      end
      S_WAIT_ROM: begin
        if (rom_ready) begin
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH, S_DRAIN: begin
        if (|hit) begin
          state_d      = S_FINISH;
          found_d      = 1'b1;
          stop_all_d   = 1'b1;
          done_d       = 1'b1;
          found_key_d  = hit_key_sel;
          found_core_d = hit_idx;
        end else if (state_q == S_DISPATCH) begin
          if (grant_valid && !exhausted_q) begin
            ack_d                    = '0;
            ack_d[grant_idx]         = 1'b1;
            chunk_base_d             = next_base_q;
            chunk_last_d             = next_base_q + KEY_WIDTH'(CHUNK_SIZE - 1);
            next_base_d              = next_sum[KEY_WIDTH-1:0];
            outstanding_d[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
            if (next_sum[KEY_WIDTH]) begin
              exhausted_d = 1'b1;
              state_d     = S_DRAIN;
            end
          end
        end else if (outstanding_q == '0) begin
          state_d = S_FINISH;
          found_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every (re)entry into WAIT_ROM starts a fresh search.
    if (state_d == S_WAIT_ROM && state_q != S_WAIT_ROM) begin
      next_base_d   = '0;
      outstanding_d = '0;
      exhausted_d   = 1'b0;
      rr_ptr_d      = '0;
      found_d       = 1'b0;
      found_key_d   = '0;
      found_core_d  = '0;
      done_d        = 1'b0;
      stop_all_d    = 1'b0;
    end

    busy_d = (state_d == S_WAIT_ROM) || (state_d == S_DISPATCH) || (state_d == S_DRAIN);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      next_base_q   <= '0;
      outstanding_q <= '0;
      exhausted_q   <= 1'b0;
      rr_ptr_q      <= '0;
      ack           <= '0;
      chunk_base    <= '0;
      chunk_last    <= '0;
      stop_all      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_key     <= '0;
      found_core    <= '0;
    end else begin
      state_q       <= state_d;
      next_base_q   <= next_base_d;
      outstanding_q <= outstanding_d;
      exhausted_q   <= exhausted_d;
      rr_ptr_q      <= rr_ptr_d;
      ack           <= ack_d;
      chunk_base    <= chunk_base_d;
      chunk_last    <= chunk_last_d;
      stop_all      <= stop_all_d;
      busy          <= busy_d;
      done          <= done_d;
      found         <= found_d;
      found_key     <= found_key_d;
      found_core    <= found_core_d;
    end
  end

endmodule

// File: tb/tb_key_space_scheduler.sv
// Directed bench for key_space_scheduler: 6-bit key space, 16-key chunks, 4 cores.
module tb_key_space_scheduler;

  localparam int unsigned NC = 4;
  localparam int unsigned KW = 6;
  localparam int unsigned CS = 16;

  logic            CLOCK_50 = 1'b0;
  logic            reset_n;
  logic            start;
  logic            rom_ready;
  logic [NC-1:0]   req;
  logic [NC-1:0]   hit;
  logic [NC*24-1:0] hit_key;
  logic [NC-1:0]   ack;
  logic [KW-1:0]   chunk_base;
  logic [KW-1:0]   chunk_last;
  logic            stop_all;
  logic            busy;
  logic            done;
  logic            found;
  logic [23:0]     found_key;
  logic [1:0]      found_core;

  int total = 0;
  int bad   = 0;
  logic [NC-1:0] ack_seen;

  key_space_scheduler #(
    .NUM_CORES (NC),
    .KEY_WIDTH (KW),
    .CHUNK_SIZE(CS)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .start     (start),
    .rom_ready (rom_ready),
    .req       (req),
    .hit       (hit),
    .hit_key   (hit_key),
    .ack       (ack),
    .chunk_base(chunk_base),
    .chunk_last(chunk_last),
    .stop_all  (stop_all),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .found_key (found_key),
    .found_core(found_core)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [NC-1:0] exp_ack,
                             input int unsigned exp_base);
    check({tag, "_ack"},  32'(ack),        32'(exp_ack));
    check({tag, "_base"}, 32'(chunk_base), 32'(exp_base));
    check({tag, "_last"}, 32'(chunk_last), 32'(exp_base + CS - 1));
  endtask

  task automatic wait_done(input int budget);
    ack_seen = '0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      ack_seen |= ack;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    rom_ready = 1'b0;
    req       = '0;
    hit       = '0;
    hit_key   = '0;
    #1;
    check("rst_ack",   32'(ack),       32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_done",  32'(done),      32'h0);
    check("rst_found", 32'(found),     32'h0);
    check("rst_key",   32'(found_key), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Full sweep with two requesting cores, no hit.
    start = 1'b1;
    tick();
    start     = 1'b0;
    check("sweep_busy", 32'(busy), 32'h1);
    rom_ready = 1'b1;
    req       = 4'b0011;
    tick();
    check("sweep_enter_ack", 32'(ack), 32'h0);
    tick(); check_grant("sweep_g0", 4'b0001, 0);
    tick(); check_grant("sweep_g1", 4'b0010, 16);
    tick(); check_grant("sweep_g2", 4'b0001, 32);
    tick(); check_grant("sweep_g3", 4'b0010, 48);
    wait_done(12);
    check("sweep_done",       32'(done),     32'h1);
    check("sweep_found",      32'(found),    32'h0);
    check("sweep_stop",       32'(stop_all), 32'h0);
    check("sweep_busy_end",   32'(busy),     32'h0);
    check("sweep_drain_ack",  32'(ack_seen), 32'h0);

    // Restart from FINISH, then a hit mid-search.
    req   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done",  32'(done),     32'h0);
    check("restart_found", 32'(found),    32'h0);
    check("restart_stop",  32'(stop_all), 32'h0);
    req = 4'b0001;
    tick();
    tick(); check_grant("restart_g0", 4'b0001, 0);
    req            = '0;
    hit            = 4'b0010;
    hit_key[47:24] = 24'h00002A;
    tick();
    hit = '0;
    check("hit_found", 32'(found),      32'h1);
    check("hit_key",   32'(found_key),  32'h00002A);
    check("hit_core",  32'(found_core), 32'h1);
    check("hit_stop",  32'(stop_all),   32'h1);
    check("hit_done",  32'(done),       32'h1);
    check("hit_ack",   32'(ack),        32'h0);
    req      = 4'b1111;
    ack_seen = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      ack_seen |= ack;
    end
    check("finish_no_ack", 32'(ack_seen),  32'h0);
    check("finish_hold",   32'(found_key), 32'h00002A);
    check("finish_stop",   32'(stop_all),  32'h1);

    // Simultaneous hits on cores 1 and 3.
    req   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    hit            = 4'b1010;
    hit_key[47:24] = 24'h123456;
    hit_key[95:72] = 24'hABCDEF;
    tick();
    hit = '0;
    check("multi_core", 32'(found_core), 32'h1);
    check("multi_key",  32'(found_key),  32'h123456);
    check("multi_done", 32'(done),       32'h1);

    // Hit and grant in the same cycle: the hit wins.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    req            = 4'b0001;
    hit            = 4'b0100;
    hit_key[71:48] = 24'h000777;
    tick();
    hit = '0;
    req = '0;
    check("coll_ack",   32'(ack),        32'h0);
    check("coll_core",  32'(found_core), 32'h2);
    check("coll_key",   32'(found_key),  32'h000777);
    check("coll_found", 32'(found),      32'h1);

    // ROM gating, then round-robin fairness across all four cores.
    rom_ready = 1'b0;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    req      = 4'b1111;
    ack_seen = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      ack_seen |= ack;
    end
    check("rom_gate_ack",  32'(ack_seen), 32'h0);
    check("rom_gate_busy", 32'(busy),     32'h1);
    rom_ready = 1'b1;
    tick();
    check("rom_enter_ack", 32'(ack), 32'h0);
    tick(); check_grant("rr_g0", 4'b0001, 0);
    tick(); check_grant("rr_g1", 4'b0010, 16);
    tick(); check_grant("rr_g2", 4'b0100, 32);
    tick(); check_grant("rr_g3", 4'b1000, 48);
    wait_done(12);
    check("rr_done",  32'(done),     32'h1);
    check("rr_found", 32'(found),    32'h0);
    check("rr_drain", 32'(ack_seen), 32'h0);

    // Asynchronous reset in the middle of dispatch.
    req   = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick(); check_grant("pre_rst_g0", 4'b0001, 0);
    tick(); check_grant("pre_rst_g1", 4'b0010, 16);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ack",  32'(ack),        32'h0);
    check("async_base", 32'(chunk_base), 32'h0);
    check("async_busy", 32'(busy),       32'h0);
    check("async_done", 32'(done),       32'h0);
    tick();
    reset_n = 1'b1;
    req     = 4'b0001;
    tick();
    check("post_rst_idle", 32'(busy), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick(); check_grant("post_rst_g0", 4'b0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
